// File: rtl/lab4_truth_table_scanner.sv
// lab4_truth_table_scanner: walks a 4-input expression block through all 16 minterms,
// captures its truth table, counts the ON-minterms and compares against EXPECTED.
module lab4_truth_table_scanner #(
    parameter int          SETTLE   = 2,
    parameter logic [15:0] EXPECTED = 16'h8F23
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    input  logic        x,
    output logic        busy,
    output logic        done,
    output logic [15:0] truth_table,
    output logic [4:0]  ones,
    output logic        match
);
    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;
    localparam logic [3:0] LAST = 4'(SETTLE - 1);
    state_t      state;
    logic [3:0]  idx;
    logic [3:0]  cnt;
    logic [15:0] tbl_nxt;
    assign {a, b, c, d} = idx;
    // Table including the bit being sampled now, so match is ready together with done.
    always_comb begin
        tbl_nxt      = truth_table;
        tbl_nxt[idx] = x;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state       <= S_IDLE;
            idx         <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            truth_table <= '0;
            ones        <= '0;
            match       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE:
                    if (start) begin
                        truth_table <= '0;
                        ones        <= '0;
                        match       <= 1'b0;
                        idx         <= '0;
                        cnt         <= '0;
                        busy        <= 1'b1;
                        state       <= S_SETTLE;
                    end
                S_SETTLE:
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= S_SAMPLE;
                    end else
                        cnt <= cnt + 4'd1;
                S_SAMPLE: begin
                    truth_table <= tbl_nxt;
                    ones        <= ones + {4'd0, x};
                    if (idx == 4'd15) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        match <= (tbl_nxt == EXPECTED);
                        state <= S_DONE;
                    end else begin
                        idx   <= idx + 4'd1;
                        state <= S_SETTLE;
                    end
                end
                S_DONE: begin
                    idx   <= '0;
                    state <= S_IDLE;
                end
                default: begin
                    idx   <= '0;
                    cnt   <= '0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
endmodule

// File: tb/tb_lab4_truth_table_scanner.sv
// tb_lab4_truth_table_scanner: scoreboard bench for three scanner builds (SETTLE = 2, 1, 15)
// driven by a truth-table model of the expression block plus random functions.
module tb_lab4_truth_table_scanner;
    localparam int NI = 3;
    typedef struct {
        int          inst;
        logic [15:0] tbl;
        int          ones;
        bit          match;
        int          t0;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [NI-1:0] start;
    logic [NI-1:0] a, b, c, d, busy, done, match;
    int            mode;
    logic [15:0]   fn;
    int            cyc = 0;
    int            dones = 0;
    int            n_chk = 0;
    int            n_fail = 0;
    exp_t          q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string nm, longint act, longint req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic bit sop(logic [3:0] m);
        bit pa, pb, pc, pd;
        {pa, pb, pc, pd} = m;
        return (!pb && !pc) || (pa && !pb) || (!pa && !pc && pd) || (pa && pc && pd);
    endfunction

    function automatic logic [15:0] expr_table();
        logic [15:0] t;
        for (int i = 0; i < 16; i++) t[i] = sop(4'(i));
        return t;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : u
        localparam int S = (g == 0) ? 2 : (g == 1) ? 1 : 15;
        logic        xs;
        logic [15:0] tbl;
        logic [4:0]  ones;
        logic [3:0]  vec;
        int          hc = 0;
        logic [3:0]  pv;
        int          bc = 0;
        int          last = 0;
        bit          post = 0;
        int          vlog[$];
        assign vec = {a[g], b[g], c[g], d[g]};

        lab4_truth_table_scanner #(.SETTLE(S)) dut (
            .clk(clk), .rst(rst), .start(start[g]),
            .a(a[g]), .b(b[g]), .c(c[g]), .d(d[g]), .x(xs),
            .busy(busy[g]), .done(done[g]), .truth_table(tbl),
            .ones(ones), .match(match[g])
        );

        // Expression stand-in: the right value only on the last cycle a vector is held.
        always @(negedge clk) begin
            if (!busy[g]) hc = 0;
            else if (hc == 0 || vec != pv) hc = 1;
            else hc++;
            pv = vec;
            xs = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : (hc == S + 1) ? fn[vec] : ~fn[vec];
        end

        always @(negedge clk) begin
            exp_t e;
            int   t0;
            bit   ok;
            if (rst) begin
                bc = 0;
                post = 0;
                vlog.delete();
            end else begin
                if (post) begin
                    check($sformatf("vec_after_done[%0d]", g), vec, 0);
                    post = 0;
                end
                if (busy[g]) begin
                    bc++;
                    vlog.push_back(int'(vec));
                end
                if (done[g]) begin
                    dones++;
                    post = 1;
                    check($sformatf("done_expected[%0d]", g), q.size() > 0, 1);
                    if (q.size() > 0) begin
                        e  = q.pop_front();
                        t0 = (e.t0 < 0) ? last + 1 : e.t0;
                        ok = (vlog.size() == 16 * (S + 1));
                        foreach (vlog[k]) if (vlog[k] != k / (S + 1)) ok = 0;
                        check($sformatf("inst[%0d]", g), g, e.inst);
                        check($sformatf("table[%0d]", g), tbl, e.tbl);
                        check($sformatf("ones[%0d]", g), ones, e.ones);
                        check($sformatf("match[%0d]", g), match[g], e.match);
                        check($sformatf("latency[%0d]", g), cyc - t0, 16 * (S + 1) + 1);
                        check($sformatf("busy_cycles[%0d]", g), bc, 16 * (S + 1));
                        check($sformatf("vec_at_done[%0d]", g), vec, 15);
                        check($sformatf("vec_sequence[%0d]", g), ok, 1);
                    end
                    last = cyc;
                    bc = 0;
                    vlog.delete();
                end
            end
        end
    end

    task automatic run(int g, int md, logic [15:0] f, int poke);
        exp_t e;
        int   n;
        bit   poked = 0;
        @(negedge clk);
        mode    = md;
        fn      = f;
        e.inst  = g;
        e.tbl   = (md == 1) ? 16'h0000 : (md == 2) ? 16'hFFFF : f;
        e.ones  = $countones(e.tbl);
        e.match = (e.tbl == 16'h8F23);
        e.t0    = cyc;
        q.push_back(e);
        n = dones;
        start[g] = 1'b1;
        @(negedge clk);
        start[g] = 1'b0;
        for (int i = 0; i < 400 && dones == n; i++) begin
            @(negedge clk);
            start[g] = 1'b0;
            if (poke >= 0 && !poked && busy[g] && {a[g], b[g], c[g], d[g]} == 4'(poke)) begin
                start[g] = 1'b1;
                poked = 1;
            end
        end
        start[g] = 1'b0;
        check("scan_complete", dones - n, 1);
    endtask

    task automatic back_to_back(logic [15:0] f);
        exp_t e;
        int   n;
        @(negedge clk);
        mode    = 0;
        fn      = f;
        e.inst  = 0;
        e.tbl   = f;
        e.ones  = $countones(f);
        e.match = (f == 16'h8F23);
        e.t0    = cyc;
        q.push_back(e);
        e.t0 = -1;
        q.push_back(e);
        n = dones;
        start[0] = 1'b1;
        for (int i = 0; i < 400 && dones - n < 2; i++) @(negedge clk);
        start[0] = 1'b0;
        check("b2b_complete", dones - n, 2);
    endtask

    initial begin
        logic [15:0] ex;
        int          n;
        rst   = 1'b1;
        start = '0;
        mode  = 0;
        fn    = '0;
        ex    = expr_table();
        #1;
        check("reset_state", {busy[0], done[0], match[0], u[0].ones, u[0].tbl, u[0].vec}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run(0, 0, ex, -1);
        run(0, 1, ex, -1);
        run(0, 2, ex, -1);
        repeat (3) run(0, 0, 16'($urandom), -1);
        run(0, 0, ex, 6);
        back_to_back(ex);
        @(negedge clk);
        mode  = 0;
        fn    = ex;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        for (int i = 0; i < 200 && !(busy[0] && u[0].vec == 4'd9); i++) @(negedge clk);
        check("reach_minterm9", u[0].vec, 9);
        n = dones;
        #2 rst = 1'b1;
        #1 check("rst_async", {busy[0], done[0], match[0], u[0].ones, u[0].tbl, u[0].vec}, 0);
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (60) @(negedge clk);
        check("no_done_after_rst", dones - n, 0);
        run(0, 0, ex, -1);
        run(1, 0, ex, -1);
        run(2, 0, ex, -1);
        run(1, 0, 16'($urandom), -1);
        repeat (5) @(negedge clk);
        check("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/lab4_truth_table_scanner.md
Name: lab4_truth_table_scanner

Overview:
- Sequential stimulus/capture stage that wraps the 4-input combinational expression block.
- Drives the expression's inputs a,b,c,d through all 16 minterms, waits a settle time, and samples the single-bit result x.
- Builds the 16-bit truth table, counts the ON-minterms, and compares the table against a parameterised expected value.
- Used on the lab board to verify expression blocks in hardware without manual switch toggling.

Parameters:
- SETTLE, 2, cycles to hold each input vector before sampling x; legal range 1..15.
- EXPECTED, 16'h8F23, expected truth table; bit i = x for minterm i (minterms 0,1,5,8,9,10,11,15).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  scan request; sampled only in IDLE
- a  output  1  minterm index bit 3 (MSB), to expression block
- b  output  1  minterm index bit 2
- c  output  1  minterm index bit 1
- d  output  1  minterm index bit 0 (LSB)
- x  input  1  expression result from expression block
- busy  output  1  high while scanning
- done  output  1  one-cycle pulse when scan completes
- table  output  16  captured truth table; bit i = x at minterm i
- ones  output  5  number of set bits in table (0..16)
- match  output  1  table == EXPECTED; valid from done pulse onward

Behaviour:
- One clock domain.
- rst is asynchronous and active-high; reset may assert at any time, including mid-scan.
- Reset values: a=b=c=d=0, busy=0, done=0, table=16'h0000, ones=0, match=0, idx=0, settle counter=0, state=IDLE.
- Input vector mapping: {a,b,c,d} = idx[3:0], driven from registers, never combinationally.
- IDLE:
  - busy=0, done=0.
  - start=1 at an edge: table<=0, ones<=0, match<=0, idx<=0, cnt<=0, go to SETTLE.
  - start=0: stay in IDLE; table, ones and match hold their last values.
- SETTLE:
  - busy=1; cnt increments each cycle.
  - When cnt==SETTLE-1: cnt<=0, go to SAMPLE.
  - The vector is therefore held for SETTLE full cycles before sampling.
- SAMPLE:
  - busy=1.
  - table[idx]<=x; ones<=ones+x.
  - idx==15: go to DONE; idx holds at 15.
  - Otherwise: idx<=idx+1, go to SETTLE.
- DONE:
  - busy=0, done=1 for exactly one cycle.
  - match<=(final table==EXPECTED). The compare uses the updated table including bit 15, so match is valid in the same cycle as done.
  - Unconditionally return to IDLE. idx<=0 so a,b,c,d return to 0.
- start behaviour:
  - Ignored in SETTLE, SAMPLE and DONE; no queuing.
  - start held high continuously: a new scan begins on the IDLE cycle following DONE.
- Timing:
  - Each minterm occupies SETTLE+1 cycles; busy is high for 16*(SETTLE+1) cycles.
  - done rises on the cycle after the 16th SAMPLE.
  - Start edge to done edge = 16*(SETTLE+1)+1 cycles. With the default SETTLE=2 this is 49.
- Width rules:
  - ones is 5 bits and must reach 16 without wrap.
  - cnt is 4 bits.
  - x is sampled as-is; X/Z on x is a bench error, not handled.
- Reset mid-scan: all state and outputs return to reset values immediately (asynchronous). No done pulse is produced. A new start is required afterwards.
- States IDLE, SETTLE, SAMPLE, DONE must be explicitly encoded. An illegal state recovers to IDLE on the next edge.

Test Plan:
- Reset, then start=1 for one cycle with x wired to a correct expression block (SOP B'C'+AB'+A'C'D+ACD), SETTLE=2 -> done pulses exactly 49 cycles after the start edge; table=16'h8F23, ones=8, match=1; busy high for 48 cycles.
- x tied to 0 -> table=16'h0000, ones=0, match=0; x tied to 1 -> table=16'hFFFF, ones=16 (no 5-bit wrap), match=0.
- Monitor a,b,c,d during a scan -> sequence 0000,0001,…,1111, each value held exactly SETTLE+1 cycles; x sampled on the last of those cycles; a,b,c,d return to 0000 after DONE.
- Pulse start while busy=1 at minterm 6 -> scan continues undisturbed, single done pulse, identical table; start held high continuously -> back-to-back scans separated by exactly one IDLE cycle.
- Assert rst mid-scan at minterm 9 -> all outputs 0 immediately without waiting for clk, no done pulse; a following start gives a full correct scan (table=16'h8F23).
- SETTLE=1 and SETTLE=15 builds -> start-to-done latency of 33 and 257 cycles respectively, with the same table=16'h8F23 result.
